// File: rtl/cpu_trace_buf_pkg.sv
// Shared types and entry-layout helpers for the VeriRISC instruction-trace buffer.
// An entry is packed {pc, opcode, ir_addr, data} with pc in the MSBs.
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_STOPPED   = 2'd3
  } state_e;

  localparam int DEF_ADDR_WIDTH   = 5;
  localparam int DEF_OPCODE_WIDTH = 3;
  localparam int DEF_DATA_WIDTH   = 8;

  function automatic int entry_w(input int aw, input int ow, input int dw);
    return 2 * aw + ow + dw;
  endfunction

  // Field LSB positions inside a packed entry.
  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int ir_lsb(input int dw);
    return dw;
  endfunction

  function automatic int op_lsb(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int pc_lsb(input int aw, input int ow, input int dw);
    return aw + ow + dw;
  endfunction

endpackage

// File: rtl/cpu_trace_buf_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Only the read-data register is reset; the array itself holds no reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 21,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // NOTE: storage arrays are deliberately left out of reset so they map onto RAM macros.
  always_ff @(posedge i_clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read of a slot being overwritten in the same cycle returns the old contents.
  always_ff @(posedge i_clock) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_trace_buf.sv
// Instruction-trace capture buffer: records one entry per executed instruction
// into a circular buffer with optional start-PC trigger, wrap/stop modes and halt detection.
module cpu_trace_buf
  import cpu_trace_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int DEPTH        = 16,
  parameter int CNT_WIDTH    = 16,
  localparam int ENTRY_W     = entry_w(ADDR_WIDTH, OPCODE_WIDTH, DATA_WIDTH),
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                    i_clock,
  input  logic                    i_rst,
  input  logic                    i_arm,
  input  logic                    i_disarm,
  input  logic                    i_wrap_mode,
  input  logic                    i_trig_en,
  input  logic [ADDR_WIDTH-1:0]   i_trig_pc,
  input  logic                    i_instr_valid,
  input  logic [ADDR_WIDTH-1:0]   i_pc_addr,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [ADDR_WIDTH-1:0]   i_ir_addr,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_halt,
  input  logic                    i_rd_en,
  output logic                    o_rd_valid,
  output logic [ENTRY_W-1:0]      o_rd_entry,
  output logic [CW-1:0]           o_count,
  output logic                    o_overflow,
  output logic                    o_halted,
  output logic [ADDR_WIDTH-1:0]   o_halt_pc,
  output logic [CNT_WIDTH-1:0]    o_instr_cnt,
  output logic [1:0]              o_state
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_e                  r_state;
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic                    r_overflow;
  logic                    r_halted;
  logic [ADDR_WIDTH-1:0]   r_halt_pc;
  logic [CNT_WIDTH-1:0]    r_instr_cnt;
  logic                    r_halt_q;
  logic                    r_rd_valid;
  logic                    r_wrap;
  logic                    r_trig_en;
  logic [ADDR_WIDTH-1:0]   r_trig_pc;

  logic                    w_full;
  logic                    w_halt_edge;
  logic                    w_capture;
  logic                    w_pop;
  logic                    w_write;
  logic                    w_overwrite;
  logic                    w_fill_stop;
  logic [CW-1:0]           w_count_nxt;
  logic [ENTRY_W-1:0]      w_wdata;

  assign w_full      = (r_count == FULL_CNT);
  assign w_halt_edge = i_halt & ~r_halt_q;
  assign w_pop       = i_rd_en & (r_count != '0);

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_capture = 1'b0;
    if (!i_arm && i_instr_valid) begin
      unique case (r_state)
        ST_CAPTURE:   w_capture = 1'b1;
        ST_WAIT_TRIG: w_capture = (i_pc_addr == r_trig_pc) && !w_halt_edge;
        default:      w_capture = 1'b0;
      endcase
    end

    // A pop in the same cycle frees a slot, so a full buffer never overwrites then.
    w_write     = w_capture && (!w_full || r_wrap || w_pop);
    w_overwrite = w_write && w_full && !w_pop;

    w_count_nxt = r_count;
    if (w_write && !w_overwrite && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_write)            w_count_nxt = r_count - CW'(1);

    w_fill_stop = w_write && !r_wrap && (w_count_nxt == FULL_CNT);
  end

  always_comb begin
    w_wdata = '0;
    w_wdata[pc_lsb(ADDR_WIDTH, OPCODE_WIDTH, DATA_WIDTH) +: ADDR_WIDTH] = i_pc_addr;
    w_wdata[op_lsb(ADDR_WIDTH, DATA_WIDTH) +: OPCODE_WIDTH]             = i_opcode;
    w_wdata[ir_lsb(DATA_WIDTH) +: ADDR_WIDTH]                           = i_ir_addr;
    w_wdata[data_lsb() +: DATA_WIDTH]                                   = i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_halted    <= 1'b0;
      r_halt_pc   <= '0;
      r_instr_cnt <= '0;
      r_halt_q    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_wrap      <= 1'b0;
      r_trig_en   <= 1'b0;
      r_trig_pc   <= '0;
    end else begin
      r_halt_q   <= i_halt;
      r_rd_valid <= w_pop;
      if (i_arm) begin
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
        r_overflow  <= 1'b0;
        r_halted    <= 1'b0;
        r_halt_pc   <= '0;
        r_instr_cnt <= '0;
        r_wrap      <= i_wrap_mode;
        r_trig_en   <= i_trig_en;
        r_trig_pc   <= i_trig_pc;
        r_state     <= i_trig_en ? ST_WAIT_TRIG : ST_CAPTURE;
      end else begin
        r_count <= w_count_nxt;
        if (w_write) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
          if (r_instr_cnt != '1) r_instr_cnt <= r_instr_cnt + CNT_WIDTH'(1);
        end
        if (w_pop || w_overwrite) r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_overwrite) r_overflow <= 1'b1;

        unique case (r_state)
          ST_WAIT_TRIG: begin
            if (w_halt_edge) begin
              r_halted  <= 1'b1;
              r_halt_pc <= i_pc_addr;
              r_state   <= ST_STOPPED;
            end else if (w_capture) begin
              r_state <= (i_disarm || w_fill_stop) ? ST_STOPPED : ST_CAPTURE;
            end else if (i_disarm) begin
              r_state <= ST_STOPPED;
            end
          end
          ST_CAPTURE: begin
            if (w_halt_edge) begin
              r_halted  <= 1'b1;
              r_halt_pc <= i_pc_addr;
              r_state   <= ST_STOPPED;
            end else if (i_disarm || w_fill_stop) begin
              r_state <= ST_STOPPED;
            end
          end
          default: ;
        endcase
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .i_clock (i_clock),
    .i_rst   (i_rst),
    .i_we    (w_write),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_re    (w_pop),
    .i_raddr (r_rd_ptr),
    .o_rdata (o_rd_entry)
  );

  assign o_rd_valid  = r_rd_valid;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_halted    = r_halted;
  assign o_halt_pc   = r_halt_pc;
  assign o_instr_cnt = r_instr_cnt;
  assign o_state     = r_state;

endmodule

// File: tb/tb_cpu_trace_buf.sv
// Directed self-checking bench for cpu_trace_buf at default parameters.
module tb_cpu_trace_buf;

  localparam int AW = 5, OW = 3, DW = 8, EW = 21, CW = 5, CNTW = 16;

  logic           clock = 1'b0;
  logic           rst = 1'b1, arm = 1'b0, disarm = 1'b0, wrap_mode = 1'b0, trig_en = 1'b0;
  logic [AW-1:0]  trig_pc = '0, pc_addr = '0, ir_addr = '0;
  logic           instr_valid = 1'b0, halt = 1'b0, rd_en = 1'b0;
  logic [OW-1:0]  opcode = '0;
  logic [DW-1:0]  data = '0;
  logic           rd_valid, overflow, halted;
  logic [EW-1:0]  rd_entry;
  logic [CW-1:0]  count;
  logic [AW-1:0]  halt_pc;
  logic [CNTW-1:0] instr_cnt;
  logic [1:0]     state;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  cpu_trace_buf dut (
    .i_clock(clock), .i_rst(rst), .i_arm(arm), .i_disarm(disarm),
    .i_wrap_mode(wrap_mode), .i_trig_en(trig_en), .i_trig_pc(trig_pc),
    .i_instr_valid(instr_valid), .i_pc_addr(pc_addr), .i_opcode(opcode),
    .i_ir_addr(ir_addr), .i_data(data), .i_halt(halt), .i_rd_en(rd_en),
    .o_rd_valid(rd_valid), .o_rd_entry(rd_entry), .o_count(count),
    .o_overflow(overflow), .o_halted(halted), .o_halt_pc(halt_pc),
    .o_instr_cnt(instr_cnt), .o_state(state)
  );

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] pc);
    return {3'b000, pc} * 8'd3 + 8'd1;
  endfunction

  function automatic logic [EW-1:0] exp_entry(input logic [AW-1:0] pc);
    return {pc, pc[2:0], ~pc, data_of(pc)};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_instr(input logic [AW-1:0] pc, input logic h);
    instr_valid = 1'b1;
    pc_addr     = pc;
    opcode      = pc[2:0];
    ir_addr     = ~pc;
    data        = data_of(pc);
    halt        = h;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic do_arm(input logic w, input logic t, input logic [AW-1:0] tp);
    wrap_mode = w; trig_en = t; trig_pc = tp; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pop(output logic v, output logic [EW-1:0] e);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    v = rd_valid;
    e = rd_entry;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state); else n_pass++;
    n_checks++; if (count !== '0) $display("FAIL reset_count: got %0d expected 0", count); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0 || rd_entry !== '0) $display("FAIL reset_rd: got %b/%0h expected 0/0", rd_valid, rd_entry); else n_pass++;
    n_checks++; if ({overflow, halted, halt_pc} !== '0 || instr_cnt !== '0)
      $display("FAIL reset_flags: got ovf=%b hlt=%b hpc=%0h cnt=%0d expected all 0", overflow, halted, halt_pc, instr_cnt); else n_pass++;
  endtask

  task automatic test_basic();
    logic v; logic [EW-1:0] e;
    do_arm(1'b0, 1'b0, '0);
    n_checks++; if (state !== 2'd2) $display("FAIL basic_state: got %0d expected 2", state); else n_pass++;
    for (int i = 0; i < 5; i++) drive_instr(AW'(i), 1'b0);
    n_checks++; if (count !== 5'd5 || instr_cnt !== 16'd5) $display("FAIL basic_count: got %0d/%0d expected 5/5", count, instr_cnt); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      pop(v, e);
      n_checks++; if (v !== 1'b1 || e !== exp_entry(AW'(i))) $display("FAIL basic_pop%0d: got %b/%0h expected 1/%0h", i, v, e, exp_entry(AW'(i))); else n_pass++;
    end
    n_checks++; if (count !== '0) $display("FAIL basic_drained: got %0d expected 0", count); else n_pass++;
    pop(v, e);
    n_checks++; if (v !== 1'b0 || e !== exp_entry(5'd4)) $display("FAIL basic_empty_pop: got %b/%0h expected 0/%0h", v, e, exp_entry(5'd4)); else n_pass++;
  endtask

  task automatic test_wrap();
    logic v; logic [EW-1:0] e;
    do_arm(1'b1, 1'b0, '0);
    for (int i = 0; i < 20; i++) drive_instr(AW'(i), 1'b0);
    n_checks++; if (count !== 5'd16 || overflow !== 1'b1 || instr_cnt !== 16'd20)
      $display("FAIL wrap_status: got cnt=%0d ovf=%b ic=%0d expected 16/1/20", count, overflow, instr_cnt); else n_pass++;
    for (int i = 4; i < 20; i++) begin
      pop(v, e);
      n_checks++; if (v !== 1'b1 || e !== exp_entry(AW'(i))) $display("FAIL wrap_pop%0d: got %b/%0h expected 1/%0h", i, v, e, exp_entry(AW'(i))); else n_pass++;
    end
  endtask

  task automatic test_stop_full();
    logic v; logic [EW-1:0] e;
    do_arm(1'b0, 1'b0, '0);
    for (int i = 0; i < 16; i++) drive_instr(AW'(i), 1'b0);
    n_checks++; if (state !== 2'd3) $display("FAIL stop_state: got %0d expected 3", state); else n_pass++;
    for (int i = 16; i < 20; i++) drive_instr(AW'(i), 1'b0);
    n_checks++; if (count !== 5'd16 || overflow !== 1'b0 || instr_cnt !== 16'd16)
      $display("FAIL stop_status: got cnt=%0d ovf=%b ic=%0d expected 16/0/16", count, overflow, instr_cnt); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      pop(v, e);
      n_checks++; if (v !== 1'b1 || e !== exp_entry(AW'(i))) $display("FAIL stop_pop%0d: got %b/%0h expected 1/%0h", i, v, e, exp_entry(AW'(i))); else n_pass++;
    end
  endtask

  task automatic test_trigger();
    logic v; logic [EW-1:0] e;
    do_arm(1'b0, 1'b1, 5'h0A);
    n_checks++; if (state !== 2'd1) $display("FAIL trig_wait_state: got %0d expected 1", state); else n_pass++;
    for (int i = 0; i < 16; i++) drive_instr(AW'(i), 1'b0);
    n_checks++; if (count !== 5'd6 || instr_cnt !== 16'd6 || state !== 2'd2)
      $display("FAIL trig_status: got cnt=%0d ic=%0d st=%0d expected 6/6/2", count, instr_cnt, state); else n_pass++;
    for (int i = 10; i < 16; i++) begin
      pop(v, e);
      n_checks++; if (v !== 1'b1 || e !== exp_entry(AW'(i))) $display("FAIL trig_pop%0d: got %b/%0h expected 1/%0h", i, v, e, exp_entry(AW'(i))); else n_pass++;
    end
  endtask

  task automatic test_halt();
    logic v; logic [EW-1:0] e;
    logic [AW-1:0] exp_pcs [3];
    exp_pcs = '{5'h01, 5'h02, 5'h17};
    do_arm(1'b0, 1'b0, '0);
    drive_instr(5'h01, 1'b0);
    drive_instr(5'h02, 1'b0);
    drive_instr(5'h17, 1'b1);
    n_checks++; if (halted !== 1'b1 || halt_pc !== 5'h17 || state !== 2'd3)
      $display("FAIL halt_flags: got hlt=%b hpc=%0h st=%0d expected 1/17/3", halted, halt_pc, state); else n_pass++;
    n_checks++; if (count !== 5'd3 || instr_cnt !== 16'd3) $display("FAIL halt_capture: got %0d/%0d expected 3/3", count, instr_cnt); else n_pass++;
    drive_instr(5'h18, 1'b1);
    halt = 1'b0;
    n_checks++; if (count !== 5'd3 || instr_cnt !== 16'd3) $display("FAIL halt_ignore: got %0d/%0d expected 3/3", count, instr_cnt); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      pop(v, e);
      n_checks++; if (v !== 1'b1 || e !== exp_entry(exp_pcs[i])) $display("FAIL halt_pop%0d: got %b/%0h expected 1/%0h", i, v, e, exp_entry(exp_pcs[i])); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic v; logic [EW-1:0] e;
    do_arm(1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) drive_instr(AW'(i), 1'b0);
    rd_en = 1'b1;
    drive_instr(5'd16, 1'b0);
    rd_en = 1'b0;
    n_checks++; if (rd_valid !== 1'b1 || rd_entry !== exp_entry(5'd0)) $display("FAIL b2b_pop: got %b/%0h expected 1/%0h", rd_valid, rd_entry, exp_entry(5'd0)); else n_pass++;
    n_checks++; if (count !== 5'd16 || overflow !== 1'b0) $display("FAIL b2b_status: got cnt=%0d ovf=%b expected 16/0", count, overflow); else n_pass++;
    for (int i = 1; i < 17; i++) begin
      pop(v, e);
      n_checks++; if (v !== 1'b1 || e !== exp_entry(AW'(i))) $display("FAIL b2b_pop%0d: got %b/%0h expected 1/%0h", i, v, e, exp_entry(AW'(i))); else n_pass++;
    end
  endtask

  task automatic test_disarm();
    do_arm(1'b0, 1'b0, '0);
    disarm = 1'b1;
    drive_instr(5'h07, 1'b0);
    n_checks++; if (state !== 2'd3 || count !== 5'd1) $display("FAIL disarm_capture: got st=%0d cnt=%0d expected 3/1", state, count); else n_pass++;
    tick();
    n_checks++; if (state !== 2'd3) $display("FAIL disarm_stopped: got %0d expected 3", state); else n_pass++;
    arm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0;
    n_checks++; if (state !== 2'd2 || count !== '0) $display("FAIL arm_priority: got st=%0d cnt=%0d expected 2/0", state, count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic v; logic [EW-1:0] e;
    do_arm(1'b1, 1'b0, '0);
    for (int i = 3; i < 6; i++) drive_instr(AW'(i), 1'b0);
    pop(v, e);
    pc_addr = 5'h1F; halt = 1'b1;
    tick();
    n_checks++; if (halted !== 1'b1 || halt_pc !== 5'h1F) $display("FAIL mid_halt: got %b/%0h expected 1/1f", halted, halt_pc); else n_pass++;
    halt = 1'b0;
    tick();
    rst = 1'b1; instr_valid = 1'b1; rd_en = 1'b1;
    tick();
    rst = 1'b0; instr_valid = 1'b0; rd_en = 1'b0;
    n_checks++; if (state !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || rd_entry !== '0)
      $display("FAIL mid_reset_core: got st=%0d cnt=%0d v=%b e=%0h expected 0/0/0/0", state, count, rd_valid, rd_entry); else n_pass++;
    n_checks++; if (overflow !== 1'b0 || halted !== 1'b0 || halt_pc !== '0 || instr_cnt !== '0)
      $display("FAIL mid_reset_flags: got ovf=%b hlt=%b hpc=%0h ic=%0d expected 0/0/0/0", overflow, halted, halt_pc, instr_cnt); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stop_full();
    test_trigger();
    test_halt();
    test_back_to_back();
    test_disarm();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
